// File: rtl/mau_pkg.sv
// Shared encodings for the load/store sequencer: access size, error cause, FSM state.
package mau_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    EC_NONE     = 2'b00,
    EC_MISALIGN = 2'b01,
    EC_RANGE    = 2'b10,
    EC_ILLEGAL  = 2'b11
  } cause_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/mau_lane.sv
// Lane extract/extend for loads and lane replace for sub-word stores (little-endian lanes).
module mau_lane
  import mau_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  size_e       i_size,
  input  logic        i_unsigned,
  input  logic [15:0] i_store,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [4:0]  w_shift_b;
  logic [4:0]  w_shift_h;
  logic [31:0] w_byte_src;
  logic [31:0] w_half_src;
  logic [31:0] w_mask;
  logic [31:0] w_ins;

  assign w_shift_b  = {i_lane, 3'b000};
  assign w_shift_h  = {i_lane[1], 4'b0000};
  assign w_byte_src = i_word >> w_shift_b;
  assign w_half_src = i_word >> w_shift_h;

  always_comb begin
    o_load = i_word;
    w_mask = 32'h0;
    w_ins  = 32'h0;
    case (i_size)
      SZ_BYTE: begin
        o_load = i_unsigned ? {24'h0, w_byte_src[7:0]}
                            : {{24{w_byte_src[7]}}, w_byte_src[7:0]};
        w_mask = 32'h0000_00FF << w_shift_b;
        w_ins  = {24'h0, i_store[7:0]} << w_shift_b;
      end
      SZ_HALF: begin
        o_load = i_unsigned ? {16'h0, w_half_src[15:0]}
                            : {{16{w_half_src[15]}}, w_half_src[15:0]};
        w_mask = 32'h0000_FFFF << w_shift_h;
        w_ins  = {16'h0, i_store} << w_shift_h;
      end
      default: begin
        o_load = i_word;
      end
    endcase
    // Word size leaves the mask empty so the merge passes the read word through.
    o_merged = (i_word & ~w_mask) | w_ins;
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of the word-wide data memory; sub-word stores are read-modify-write.
// Optional macro MAU_ALIGN_TRAP_EN: report misaligned half/word accesses instead of force-aligning them.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DM_AW = 6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] LoadData,
  output logic        Err,
  output logic [1:0]  ErrCause,
  output logic [29:0] DmAd,
  output logic [31:0] DmWrData,
  output logic        DmMemWr,
  input  logic [31:0] DmRdData
);

  // Handshake: Req is sampled only while Busy=0; once accepted, Busy stays high until the
  // single-cycle Done pulse, and LoadData/Err/ErrCause then hold until the next accepted Req.

  state_e      r_state;
  logic        r_is_load;
  size_e       r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;
  logic [15:0] r_store;
  logic [31:0] r_load_data;
  logic        r_err;
  logic [1:0]  r_err_cause;
  logic [29:0] r_dm_ad;
  logic [31:0] r_dm_wr_data;

  logic        w_illegal;
  logic        w_misalign;
  logic        w_range;
  cause_e      w_cause;
  logic [1:0]  w_lane;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign w_illegal = (MemRead == MemWrite) || (Size == SZ_ILL);
  assign w_range   = {1'b0, Addr[31:2]} >= (31'd1 << DM_AW);
`ifdef MAU_ALIGN_TRAP_EN
  assign w_misalign = ((Size == SZ_HALF) && Addr[0]) ||
                      ((Size == SZ_WORD) && (Addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Forcing the low address bits is harmless with the trap on: misaligned requests never reach MERGE.
  assign w_lane = (Size == SZ_HALF) ? {Addr[1], 1'b0} :
                  (Size == SZ_WORD) ? 2'b00 : Addr[1:0];

  always_comb begin
    w_cause = EC_NONE;
    if (w_illegal)       w_cause = EC_ILLEGAL;
    else if (w_misalign) w_cause = EC_MISALIGN;
    else if (w_range)    w_cause = EC_RANGE;
  end

  mau_lane u_lane (
    .i_word     (DmRdData),
    .i_lane     (r_lane),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_store    (r_store),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state      <= ST_IDLE;
      r_is_load    <= 1'b0;
      r_size       <= SZ_BYTE;
      r_unsigned   <= 1'b0;
      r_lane       <= 2'b00;
      r_store      <= 16'h0;
      r_load_data  <= 32'h0;
      r_err        <= 1'b0;
      r_err_cause  <= 2'b00;
      r_dm_ad      <= 30'h0;
      r_dm_wr_data <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Req) begin
            r_is_load   <= MemRead;
            r_size      <= size_e'(Size);
            r_unsigned  <= Unsigned;
            r_lane      <= w_lane;
            r_store     <= StoreData[15:0];
            r_load_data <= 32'h0;
            r_err       <= (w_cause != EC_NONE);
            r_err_cause <= w_cause;
            if (w_cause != EC_NONE) begin
              r_state <= ST_RESP;
            end else begin
              r_dm_ad <= Addr[31:2];
              if (!MemRead && (Size == SZ_WORD)) begin
                r_dm_wr_data <= StoreData;
                r_state      <= ST_WRITE;
              end else begin
                r_state <= ST_READ;
              end
            end
          end
        end
        ST_READ:  r_state <= ST_MERGE;
        ST_MERGE: begin
          if (r_is_load) begin
            r_load_data <= w_load;
            r_state     <= ST_RESP;
          end else begin
            r_dm_wr_data <= w_merged;
            r_state      <= ST_WRITE;
          end
        end
        ST_WRITE: r_state <= ST_RESP;
        ST_RESP:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign Busy     = (r_state != ST_IDLE);
  assign Done     = (r_state == ST_RESP);
  assign DmMemWr  = (r_state == ST_WRITE);
  assign LoadData = r_load_data;
  assign Err      = r_err;
  assign ErrCause = r_err_cause;
  assign DmAd     = r_dm_ad;
  assign DmWrData = r_dm_wr_data;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-level reference memory model, directed plan cases, random traffic.
`timescale 1ns/1ps
module tb_mem_access_unit;

  localparam int NW = 64;

  // clock / reset
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Req = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic        Unsigned = 1'b0;
  logic [31:0] Addr = 32'h0;
  logic [31:0] StoreData = 32'h0;
  logic        Busy, Done, Err, DmMemWr;
  logic [31:0] LoadData, DmWrData;
  logic [1:0]  ErrCause;
  logic [29:0] DmAd;
  logic [31:0] dm_rd;

  always #5 Clk = ~Clk;

  mem_access_unit #(.DM_AW(6)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .MemRead(MemRead), .MemWrite(MemWrite),
    .Size(Size), .Unsigned(Unsigned), .Addr(Addr), .StoreData(StoreData),
    .Busy(Busy), .Done(Done), .LoadData(LoadData), .Err(Err), .ErrCause(ErrCause),
    .DmAd(DmAd), .DmWrData(DmWrData), .DmMemWr(DmMemWr), .DmRdData(dm_rd)
  );

  // data memory: registered read every non-write cycle, plus a backdoor write port
  logic [31:0] mem [NW];
  logic        bd_we = 1'b0;
  logic [5:0]  bd_addr = 6'h0;
  logic [31:0] bd_data = 32'h0;
  int          wr_pulses = 0;

  always @(posedge Clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (DmMemWr) mem[DmAd[5:0]] <= DmWrData;
    if (!DmMemWr) dm_rd <= mem[DmAd[5:0]];
    if (DmMemWr) wr_pulses <= wr_pulses + 1;
  end

  // scoreboard
  logic [31:0] ref_mem [NW];
  logic [31:0] exp_q [$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    int wi, off;
    wi  = int'(a / 4);
    off = int'(a % 4);
    return 8'((ref_mem[wi] >> (8 * off)) & 32'hFF);
  endfunction

  function automatic void ref_set_byte(input logic [31:0] a, input logic [7:0] b);
    int wi, off;
    wi  = int'(a / 4);
    off = int'(a % 4);
    ref_mem[wi] = (ref_mem[wi] & ~(32'hFF << (8 * off))) | (32'(b) << (8 * off));
  endfunction

  // driver tasks
  task automatic bd_write(input int w, input logic [31:0] d);
    @(negedge Clk);
    bd_we = 1'b1; bd_addr = w[5:0]; bd_data = d;
    @(negedge Clk);
    bd_we = 1'b0;
    ref_mem[w] = d;
  endtask

  task automatic do_req(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic us, input logic [31:0] a, input logic [31:0] sd);
    logic [1:0]  e_cause;
    logic [31:0] ea, ev;
    int          e_lat, e_wr, nbytes, lat, w0;
    bit          done;
    nbytes  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e_cause = 2'd0; ea = a; ev = 32'h0; e_lat = 1; e_wr = 0;
    if (rd == wr || sz == 2'd3) e_cause = 2'd3;
`ifdef MAU_ALIGN_TRAP_EN
    else if (a % nbytes != 0) e_cause = 2'd1;
`endif
    else begin
      ea = a - (a % nbytes);
      if (ea / 4 >= NW) e_cause = 2'd2;
    end
    if (e_cause == 2'd0) begin
      if (rd) begin
        for (int i = 0; i < nbytes; i++) ev |= 32'(ref_byte(ea + i)) << (8 * i);
        if (!us && nbytes < 4 && ev[8 * nbytes - 1]) ev |= 32'hFFFF_FFFF << (8 * nbytes);
        e_lat = 3;
      end else begin
        for (int i = 0; i < nbytes; i++) ref_set_byte(ea + i, 8'(sd >> (8 * i)));
        e_lat = (nbytes == 4) ? 2 : 4;
        e_wr  = 1;
      end
    end
    exp_q.push_back(ev);

    @(negedge Clk);
    Req = 1'b1; MemRead = rd; MemWrite = wr; Size = sz; Unsigned = us; Addr = a; StoreData = sd;
    w0 = wr_pulses;
    @(posedge Clk); #1;
    Req = 1'b0;
    lat = 1; done = 0;
    while (!done && lat <= 8) begin
      if (Done) done = 1;
      else begin
        @(posedge Clk); #1;
        lat++;
      end
    end
    check({tag, "_lat"}, done ? lat : 0, e_lat);
    check({tag, "_err"}, Err, (e_cause != 2'd0));
    check({tag, "_cause"}, ErrCause, e_cause);
    ev = exp_q.pop_front();
    if (rd || e_cause != 2'd0) check({tag, "_ld"}, LoadData, ev);
    check({tag, "_nwr"}, wr_pulses - w0, e_wr);
    @(posedge Clk); #1;
    check({tag, "_pulse"}, {Done, Busy}, 2'b00);
    if (e_wr == 1) check({tag, "_mem"}, mem[ea / 4], ref_mem[ea / 4]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w_addr, w_exp;
    int w0, n_done;
    bit prev_done;

    #1 Reset = 1'b0;
    #1;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_err", {Err, ErrCause}, 0);
    check("rst_ld", LoadData, 0);
    check("rst_ad", DmAd, 0);
    check("rst_wd", DmWrData, 0);
    check("rst_wr", DmMemWr, 0);
    for (int w = 0; w < NW; w++) bd_write(w, $urandom);
    @(negedge Clk);
    Reset = 1'b1;

    // directed: byte loads
    bd_write(3, 32'h80FF7F01);
    do_req("lb_e", 1, 0, 2'd0, 0, 32'h0E, 32'h0);
    check("lb_e_k", LoadData, 32'hFFFF_FFFF);
    do_req("lb_f", 1, 0, 2'd0, 0, 32'h0F, 32'h0);
    check("lb_f_k", LoadData, 32'hFFFF_FF80);
    do_req("lbu_f", 1, 0, 2'd0, 1, 32'h0F, 32'h0);
    check("lbu_f_k", LoadData, 32'h0000_0080);

    // directed: half store, word store/load
    bd_write(3, 32'h11223344);
    do_req("sh", 0, 1, 2'd1, 0, 32'h0E, 32'h0000_ABCD);
    check("sh_k", mem[3], 32'hABCD_3344);
    do_req("sw", 0, 1, 2'd2, 0, 32'h08, 32'hDEAD_BEEF);
    do_req("lw", 1, 0, 2'd2, 0, 32'h08, 32'h0);
    check("lw_k", LoadData, 32'hDEAD_BEEF);

    // directed: errors
    bd_write(1, 32'hCAFE_8765);
    do_req("lh_5", 1, 0, 2'd1, 0, 32'h05, 32'h0);
`ifdef MAU_ALIGN_TRAP_EN
    check("lh_5_k", ErrCause, 2'b01);
`else
    check("lh_5_k", LoadData, 32'hFFFF_8765);
`endif
    do_req("lw_oor", 1, 0, 2'd2, 0, 32'h100, 32'h0);
    check("lw_oor_k", ErrCause, 2'b10);
    do_req("rdwr", 1, 1, 2'd2, 0, 32'h08, 32'h0);
    check("rdwr_k", ErrCause, 2'b11);
    do_req("sz11", 1, 0, 2'd3, 0, 32'h08, 32'h0);

    // reset during WRITE
    bd_write(5, 32'h5555_AAAA);
    @(negedge Clk);
    Req = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Size = 2'd2; Addr = 32'h14; StoreData = 32'h1234_5678;
    @(posedge Clk); #1;
    Req = 1'b0;
    check("rstw_wr_on", DmMemWr, 1);
    #2 Reset = 1'b0;
    #1;
    check("rstw_wr_off", DmMemWr, 0);
    check("rstw_busy", Busy, 0);
    check("rstw_done", Done, 0);
    @(posedge Clk); #1;
    check("rstw_mem", mem[5], 32'h5555_AAAA);
    @(negedge Clk);
    Reset = 1'b1;
    do_req("post_rst", 1, 0, 2'd2, 0, 32'h14, 32'h0);

    // back-to-back: Req held high, garbage stores offered while busy
    w0 = wr_pulses; n_done = 0; prev_done = 0;
    @(negedge Clk);
    w_addr = 32'($urandom_range(0, NW - 1)) << 2;
    Req = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Size = 2'd2; Addr = w_addr;
    exp_q.push_back(ref_mem[w_addr / 4]);
    for (int k = 0; k < 40; k++) begin
      @(posedge Clk); #1;
      if (Done) begin
        n_done++;
        w_exp = exp_q.pop_front();
        check("b2b_ld", LoadData, w_exp);
      end
      if (prev_done) check("b2b_idle", Busy, 0);
      prev_done = Done;
      if (!Busy) begin
        w_addr = 32'($urandom_range(0, NW - 1)) << 2;
        MemRead = 1'b1; MemWrite = 1'b0; Size = 2'd2; Addr = w_addr;
        exp_q.push_back(ref_mem[w_addr / 4]);
      end else begin
        MemRead = 1'b0; MemWrite = 1'b1; Size = 2'($urandom_range(0, 2));
        Addr = 32'($urandom_range(0, 255)); StoreData = $urandom;
      end
    end
    Req = 1'b0;
    if (!Busy && exp_q.size() > 0) void'(exp_q.pop_back());
    check("b2b_ndone", n_done, 10);
    check("b2b_nwr", wr_pulses - w0, 0);
    check("b2b_q", exp_q.size(), 0);
    @(posedge Clk); #1;
    @(posedge Clk); #1;

    // random traffic
    for (int n = 0; n < 60; n++) begin
      logic rd, wr;
      logic [31:0] a;
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 7) == 0) ? rd : !rd;
      case ($urandom_range(0, 7))
        0:       a = 32'($urandom_range(256, 1023));
        1:       a = $urandom;
        default: a = 32'($urandom_range(0, 255));
      endcase
      do_req("rnd", rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom);
    end

    for (int w = 0; w < NW; w++) check("final_mem", mem[w], ref_mem[w]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
